// File: rtl/serial_alu_sequencer_if.sv
// Handshake and data bundle between a requester and the bit-serial ALU sequencer.
interface serial_alu_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, op, A, B,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/sub/inc sequencer: feeds operands LSB-first through a 1-bit full adder
// with a registered carry and assembles a WIDTH-bit result plus carry/overflow flags.
module serial_alu_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_alu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_ADD_INC = 2'b01,
    OP_SUB     = 2'b10,
    OP_INC     = 2'b11
  } op_t;

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             sum;
  logic             carry;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    sum   = a_sr[0] ^ b_sr[0] ^ c;
    carry = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & c);
  end

  // SUB is A + ~B + 1; INC is A + 0 + 1, so B is never consulted for INC.
  always_comb begin
    b_load = bus.B;
    c_load = 1'b1;
    case (op_t'(bus.op))
      OP_ADD:     c_load = 1'b0;
      OP_ADD_INC: b_load = bus.B;
      OP_SUB:     b_load = ~bus.B;
      OP_INC:     b_load = '0;
      default:    b_load = bus.B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.A;
            b_sr   <= b_load;
            c      <= c_load;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          res_sr <= {sum, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          c      <= carry;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_q <= carry;
            ovf_q  <= c ^ carry;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_sr;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Bit-serial front end for the 1-bit add/increment slice. Latches two WIDTH-bit operands and an opcode, then feeds the operand bits LSB-first through a 1-bit full-adder datapath with a registered carry, one bit per clock. It assembles the WIDTH-bit result, carry-out and signed-overflow flag, and signals completion with a one-cycle `done` pulse. It sits directly upstream of the 1-bit slice and is the block that turns that slice into a multi-bit ALU.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits, ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: request a new operation; sampled only when not busy.
- `op`  input  2: 00 ADD (A+B), 01 ADD_INC (A+B+1), 10 SUB (A−B = A+~B+1), 11 INC (A+1).
- `A`  input  WIDTH: operand A; latched on accepted start.
- `B`  input  WIDTH: operand B; latched on accepted start; ignored for INC.
- `busy`  output  1: high while bits are being processed.
- `done`  output  1: one-cycle pulse when the result is final.
- `result`  output  WIDTH: assembled sum; holds until the next accepted start.
- `cout`  output  1: carry out of the MSB. For SUB, 1 means no borrow.
- `overflow`  output  1: signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.

## Operation
- States: IDLE, RUN, DONE.
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `result`, `cout`, `overflow`, bit counter and carry flop all go to 0.
  - Reset overrides every other input.
- IDLE or DONE with `start`=1:
  - Load operand shift register `a_sr`←A.
  - Load `b_sr`←B for ADD/ADD_INC, ~B for SUB, 0 for INC.
  - Carry flop ← 0 for ADD, 1 for ADD_INC/SUB/INC.
  - Bit counter ← 0.
  - Go to RUN.
- RUN, each edge:
  - sum = a_sr[0] ^ b_sr[0] ^ c.
  - c ← (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & c).
  - Shift sum into the result shift register from the MSB end.
  - Shift `a_sr` and `b_sr` right by one.
  - Increment the counter.
- On the edge that processes bit WIDTH−1:
  - Capture `cout` = carry out of that bit.
  - Capture `overflow` = carry into that bit XOR `cout`.
  - Go to DONE.
- DONE lasts one cycle, then IDLE, unless `start`=1 in DONE (see Timing).
- `start` while in RUN is ignored. There is no queuing, and operands and op are not re-sampled.
- While in RUN, `result`, `cout` and `overflow` are not guaranteed. They are defined only from `done` onward, and held through IDLE.
- Arithmetic is modulo 2^WIDTH. No saturation.
- `op` and operands are don't-care except on the accepting edge.

## Timing
- Edge E0 samples `start`=1 in IDLE/DONE.
  - `busy`=1 from after E0.
  - Bit k is processed at edge E(k+1).
- After edge E(WIDTH):
  - `busy`=0 and `done`=1.
  - `result`, `cout` and `overflow` are final.
- Latency: WIDTH cycles from the accepting edge to `done` high.
- `done` falls after one cycle.
- Back-to-back: `start`=1 during the `done` cycle is accepted at that edge.
  - Sustained throughput: one operation per WIDTH cycles.
  - `busy` goes high on the same edge that `done` falls.
- `busy` and `done` are never high together.
- Reset mid-RUN aborts the operation. No `done` pulse is produced and outputs clear at that edge.
- `start` held high continuously restarts at every DONE. This is legal.

## Test plan
- Reset, then ADD A=0x3C B=0x05 (WIDTH=8) -> `done` exactly 8 cycles after the start edge; `result`=0x41, `cout`=0, `overflow`=0; `busy` high for exactly 8 cycles.
- ADD_INC A=0xFF B=0x00 -> `result`=0x00, `cout`=1, `overflow`=0. Then INC A=0x7F -> `result`=0x80, `cout`=0, `overflow`=1.
- SUB A=0x05 B=0x07 -> `result`=0xFE, `cout`=0 (borrow), `overflow`=0. SUB A=0x80 B=0x01 -> `result`=0x7F, `cout`=1, `overflow`=1.
- Start ADD 0x10+0x20, and pulse `start` with op=SUB A=0xFF B=0xFF at cycle 3 of RUN -> request ignored; `result`=0x30 at `done`, and no second `done`.
- Back-to-back: assert `start` in the `done` cycle with ADD 0x01+0x01 -> accepted; prior result 0x30 visible during `done`; new `done` 8 cycles later with `result`=0x02, and no idle cycle in between.
- Assert `rst_n`=0 for one cycle during bit 4 of RUN -> all outputs 0 next cycle, state IDLE, no `done`; a subsequent ADD 0xAA+0x55 -> `result`=0xFF, `cout`=0.
